// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by the bus interface, the storage array and the responder FSM.
package dmem_pkg;

   localparam int WORD_W   = 64;
   localparam int OFFSET_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   // Misaligned, or any address bit above the array's byte range is set.
   function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int depth_log2);
      return (addr[OFFSET_W-1:0] != '0) || ((addr >> (depth_log2 + OFFSET_W)) != '0);
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the core's memory initiator (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
   import dmem_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [WORD_W-1:0] req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [WORD_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// Single-port 64-bit word storage: synchronous write, index-addressed read
// sampled by the responder on the access edge.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  CLK,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] idx,
   input  logic [WORD_W-1:0]     wdata,
   output logic [WORD_W-1:0]     rdata
);

   logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

   // NOTE: storage has no reset branch; contents survive reset and map onto plain RAM.
   always_ff @(posedge CLK) begin
      if (we) mem[idx] <= wdata;
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Slow data-memory target: accepts one request, waits LATENCY cycles,
// performs the access, then holds the response until the initiator takes it.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input logic             CLK,
   input logic             resetl,
   dmem_responder_if.slave bus
);

   localparam int CNT_W = 5;
   // The access fires on the edge where cnt==1, LATENCY+1 edges after acceptance.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY + 1);

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic                cap_write;
   logic [WORD_W-1:0]   cap_addr;
   logic [WORD_W-1:0]   cap_wdata;
   logic                accept, access, rsp_done;
   logic                acc_err;
   logic [WORD_W-1:0]   arr_rdata;

   assign acc_err = addr_err(cap_addr, DEPTH_LOG2);

   dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
      .CLK   (CLK),
      .we    (access && cap_write && !acc_err),
      .idx   (cap_addr[DEPTH_LOG2+2:OFFSET_W]),
      .wdata (cap_wdata),
      .rdata (arr_rdata)
   );

   // NOTE: reset is sampled on the clock edge only, so it sits inside the clocked branch.
   always_ff @(posedge CLK) begin
      if (!resetl) state <= IDLE;
      else         state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      accept        = 1'b0;
      access        = 1'b0;
      rsp_done      = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept    = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt == CNT_W'(1)) begin
               access    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: all state below uses non-blocking assignment so every register sees pre-edge values.
   always_ff @(posedge CLK) begin
      if (!resetl) begin
         cnt           <= '0;
         cap_write     <= 1'b0;
         cap_addr      <= '0;
         cap_wdata     <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            cnt       <= CNT_LOAD;
            cap_write <= bus.req_write;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
         end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
         end

         if (access) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= acc_err;
            bus.rsp_rdata <= (acc_err || cap_write) ? '0 : arr_rdata;
         end else if (rsp_done) begin
            bus.rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with LATENCY=2 for the
// functional sequence, one with LATENCY=0 for back-to-back throughput.
module tb_dmem_responder;

   logic CLK = 1'b0;
   logic resetl;
   int   checks = 0;
   int   passed = 0;

   always #5 CLK = ~CLK;

   dmem_responder_if bus2 ();
   dmem_responder_if bus0 ();

   dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) u_dut2 (
      .CLK    (CLK),
      .resetl (resetl),
      .bus    (bus2)
   );

   dmem_responder #(.DEPTH_LOG2(8), .LATENCY(0)) u_dut0 (
      .CLK    (CLK),
      .resetl (resetl),
      .bus    (bus0)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Full transaction on the LATENCY=2 instance with a bounded wait for the response.
   task automatic do_req(input string tag, input logic w, input logic [63:0] a, input logic [63:0] d,
                         output logic [63:0] rd, output logic er);
      int n;
      bus2.req_valid = 1'b1;
      bus2.req_write = w;
      bus2.req_addr  = a;
      bus2.req_wdata = d;
      step();
      bus2.req_valid = 1'b0;
      n = 0;
      while (!bus2.rsp_valid && n < 50) begin
         step();
         n++;
      end
      check({tag, " rsp_valid_seen"}, 64'(bus2.rsp_valid), 64'd1);
      rd = bus2.rsp_rdata;
      er = bus2.rsp_err;
      bus2.rsp_ready = 1'b1;
      step();
      bus2.rsp_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] rd;
      logic        er;
      logic [63:0] word0_val;
      logic [63:0] word20_val;
      logic [63:0] v0;
      logic [8:0]  exp_rr;
      logic [8:0]  exp_rv;
      logic [63:0] hold_rdata;
      logic        hold_err;

      word0_val  = 64'hA5A5_0000_1234_5678;
      word20_val = 64'h1234_5678_9ABC_DEF0;
      v0         = 64'h0BAD_F00D_0000_ABCD;

      resetl         = 1'b0;
      bus2.req_valid = 1'b0;
      bus2.req_write = 1'b0;
      bus2.req_addr  = '0;
      bus2.req_wdata = '0;
      bus2.rsp_ready = 1'b0;
      bus0.req_valid = 1'b0;
      bus0.req_write = 1'b0;
      bus0.req_addr  = '0;
      bus0.req_wdata = '0;
      bus0.rsp_ready = 1'b0;

      step();
      step();
      check("reset rsp_valid", 64'(bus2.rsp_valid), 64'd0);
      check("reset rsp_err",   64'(bus2.rsp_err),   64'd0);
      check("reset rsp_rdata", bus2.rsp_rdata,      64'd0);
      resetl = 1'b1;
      step();
      check("post-reset req_ready", 64'(bus2.req_ready), 64'd1);

      // Store 0x10 with hand-stepped timing: accept at edge 0, response after edge 3.
      bus2.req_valid = 1'b1;
      bus2.req_write = 1'b1;
      bus2.req_addr  = 64'h10;
      bus2.req_wdata = 64'hDEADBEEF_CAFEF00D;
      step();
      bus2.req_valid = 1'b0;
      check("edge0 req_ready", 64'(bus2.req_ready), 64'd0);
      check("edge0 rsp_valid", 64'(bus2.rsp_valid), 64'd0);
      step();
      check("edge1 rsp_valid", 64'(bus2.rsp_valid), 64'd0);
      step();
      check("edge2 rsp_valid", 64'(bus2.rsp_valid), 64'd0);
      step();
      check("edge3 rsp_valid", 64'(bus2.rsp_valid), 64'd1);
      check("store rsp_err",   64'(bus2.rsp_err),   64'd0);
      check("store rsp_rdata", bus2.rsp_rdata,      64'd0);
      bus2.rsp_ready = 1'b1;
      step();
      bus2.rsp_ready = 1'b0;
      check("after handshake rsp_valid", 64'(bus2.rsp_valid), 64'd0);
      check("after handshake req_ready", 64'(bus2.req_ready), 64'd1);

      do_req("load 0x10", 1'b0, 64'h10, 64'd0, rd, er);
      check("load 0x10 rdata", rd, 64'hDEADBEEF_CAFEF00D);
      check("load 0x10 err",   64'(er), 64'd0);

      do_req("store 0x0", 1'b1, 64'h0, word0_val, rd, er);
      check("store 0x0 err", 64'(er), 64'd0);

      // Error cases: misaligned load, out-of-range store aliasing word 0, misaligned store near 0x10.
      do_req("load 0x13", 1'b0, 64'h13, 64'd0, rd, er);
      check("load 0x13 err",   64'(er), 64'd1);
      check("load 0x13 rdata", rd, 64'd0);
      do_req("store 0x800", 1'b1, 64'h800, 64'hFFFF_FFFF_FFFF_FFFF, rd, er);
      check("store 0x800 err",   64'(er), 64'd1);
      check("store 0x800 rdata", rd, 64'd0);
      do_req("store 0x14", 1'b1, 64'h14, 64'h1111_2222_3333_4444, rd, er);
      check("store 0x14 err", 64'(er), 64'd1);
      do_req("load 0x0", 1'b0, 64'h0, 64'd0, rd, er);
      check("word0 unchanged", rd, word0_val);
      do_req("load 0x10 again", 1'b0, 64'h10, 64'd0, rd, er);
      check("word2 unchanged", rd, 64'hDEADBEEF_CAFEF00D);

      // Backpressure: hold the response for 10 cycles while pulsing new requests.
      bus2.req_valid = 1'b1;
      bus2.req_write = 1'b0;
      bus2.req_addr  = 64'h10;
      step();
      bus2.req_valid = 1'b0;
      step();
      step();
      step();
      check("bp rsp_valid rise", 64'(bus2.rsp_valid), 64'd1);
      hold_rdata = 64'hDEADBEEF_CAFEF00D;
      hold_err   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus2.req_valid = i[0];
         bus2.req_write = 1'b1;
         bus2.req_addr  = 64'h0;
         bus2.req_wdata = 64'hBADB_ADBA_DBAD_BADB;
         step();
         check("bp rsp_valid", 64'(bus2.rsp_valid), 64'd1);
         check("bp rsp_rdata", bus2.rsp_rdata, hold_rdata);
         check("bp rsp_err",   64'(bus2.rsp_err), 64'(hold_err));
      end
      bus2.req_valid = 1'b0;
      bus2.rsp_ready = 1'b1;
      step();
      bus2.rsp_ready = 1'b0;
      check("bp release rsp_valid", 64'(bus2.rsp_valid), 64'd0);
      do_req("load 0x0 after bp", 1'b0, 64'h0, 64'd0, rd, er);
      check("bp pulses ignored", rd, word0_val);

      // Reset in the middle of a store: the store must be discarded.
      do_req("store 0x20", 1'b1, 64'h20, word20_val, rd, er);
      bus2.req_valid = 1'b1;
      bus2.req_write = 1'b1;
      bus2.req_addr  = 64'h20;
      bus2.req_wdata = 64'h55;
      step();
      bus2.req_valid = 1'b0;
      step();
      resetl = 1'b0;
      step();
      check("midreset rsp_valid", 64'(bus2.rsp_valid), 64'd0);
      resetl = 1'b1;
      step();
      check("midreset req_ready", 64'(bus2.req_ready), 64'd1);
      for (int i = 0; i < 4; i++) step();
      check("midreset no response", 64'(bus2.rsp_valid), 64'd0);
      do_req("load 0x20", 1'b0, 64'h20, 64'd0, rd, er);
      check("load 0x20 pre-existing", rd, word20_val);

      // LATENCY=0: store then loads with req_valid and rsp_ready held high; 3-cycle period.
      exp_rr = 9'b100100100;
      exp_rv = 9'b010010010;
      bus0.req_valid = 1'b1;
      bus0.req_write = 1'b1;
      bus0.req_addr  = 64'h8;
      bus0.req_wdata = v0;
      bus0.rsp_ready = 1'b1;
      check("lat0 idle req_ready", 64'(bus0.req_ready), 64'd1);
      step();
      bus0.req_write = 1'b0;
      for (int k = 0; k < 9; k++) begin
         check($sformatf("lat0 req_ready k%0d", k), 64'(bus0.req_ready), 64'(exp_rr[k]));
         check($sformatf("lat0 rsp_valid k%0d", k), 64'(bus0.rsp_valid), 64'(exp_rv[k]));
         if (exp_rv[k]) check($sformatf("lat0 rsp_rdata k%0d", k), bus0.rsp_rdata, (k == 1) ? 64'd0 : v0);
         if (k < 8) step();
      end
      bus0.req_valid = 1'b0;
      bus0.rsp_ready = 1'b0;
      step();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
